atomik_event_packer: RTL and testbench

Serializes ATOMIK core events into a byte-framed stream for the UART transmitter. It sits downstream of the event output buffer: it consumes one event per valid/ready handshake and emits a fixed-length frame (sync, flags, address high, address low, optional checksum) one byte per handshake. It also keeps frame and stall telemetry so host-side tooling can reconcile its counts against the event counters.

---
 rtl/atomik_pkg.sv | 42 ++++
 rtl/atomik_event_packer.sv | 113 +++++++++++
 tb/tb_atomik_event_packer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/atomik_pkg.sv
// Shared definitions for the ATOMIK event packer: state encoding, frame constants, FLAGS layout.
package atomik_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_FLAGS = 3'd2,
    ST_AHI   = 3'd3,
    ST_ALO   = 3'd4,
    ST_CSUM  = 3'd5
  } pk_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int FLG_DELTA     = 7;
  localparam int FLG_FIRST     = 6;
  localparam int FLG_DROP      = 5;
  localparam int FLG_ZERO      = 4;
  localparam int FLG_DVAL_LSB  = 0;

  localparam int FRAME_LEN_BASE = 4;
  localparam int FRAME_LEN_CSUM = 5;

  typedef struct packed {
    logic [7:0]  flags;
    logic [15:0] addr;
  } ev_hold_t;

  function automatic logic [7:0] pack_flags(input logic delta, input logic first_touch,
                                            input logic drop_invalid, input logic is_zero,
                                            input logic [3:0] delta_val);
    logic [7:0] f;
    f = '0;
    f[FLG_DELTA]               = delta;
    f[FLG_FIRST]               = first_touch;
    f[FLG_DROP]                = drop_invalid;
    f[FLG_ZERO]                = is_zero;
    f[FLG_DVAL_LSB +: 4]       = delta_val;
    return f;
  endfunction

endpackage

// File: rtl/atomik_event_packer.sv
// Packs one event per handshake into a SYNC/FLAGS/AHI/ALO[/CSUM] byte frame; SYNC appears the cycle after capture, bytes hold under tx_ready=0.
// ATOMIK_PACKER_CHECKSUM_EN adds the trailing CSUM byte; ev_ready is combinational from tx_ready in the last byte.
module atomik_event_packer
  import atomik_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic              ev_delta,
  input  logic              ev_first_touch,
  input  logic              ev_drop_invalid,
  input  logic              ev_is_zero,
  input  logic [ADDR_W-1:0] ev_addr,
  input  logic [3:0]        ev_delta_val,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [31:0]       cnt_frames,
  output logic [31:0]       cnt_tx_stalls
);

`ifdef ATOMIK_PACKER_CHECKSUM_EN
  localparam pk_state_t LAST_ST = ST_CSUM;
`else
  localparam pk_state_t LAST_ST = ST_ALO;
`endif

  pk_state_t   state_q, state_d;
  ev_hold_t    hold_q, hold_d;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] cnt_frames_q, cnt_tx_stalls_q;

  logic tx_hs, in_last, capture;

  function automatic logic [7:0] frame_byte(input pk_state_t st, input ev_hold_t h);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      ST_SYNC:  b = SYNC_BYTE;
      ST_FLAGS: b = h.flags;
      ST_AHI:   b = h.addr[15:8];
      ST_ALO:   b = h.addr[7:0];
`ifdef ATOMIK_PACKER_CHECKSUM_EN
      ST_CSUM:  b = h.flags ^ h.addr[15:8] ^ h.addr[7:0];
`endif
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

  assign tx_hs    = tx_valid_q && tx_ready;
  assign in_last  = (state_q == LAST_ST);
  assign ev_ready = (state_q == ST_IDLE) || (in_last && tx_ready);
  assign capture  = ev_valid && ev_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (capture) begin
      // Capture wins over the last-byte advance so back-to-back frames have no bubble.
      hold_d.flags = pack_flags(ev_delta, ev_first_touch, ev_drop_invalid, ev_is_zero, ev_delta_val);
      hold_d.addr  = 16'(ev_addr);
      state_d      = ST_SYNC;
    end else if (tx_hs) begin
      case (state_q)
        ST_SYNC:  state_d = ST_FLAGS;
        ST_FLAGS: state_d = ST_AHI;
        ST_AHI:   state_d = ST_ALO;
`ifdef ATOMIK_PACKER_CHECKSUM_EN
        ST_ALO:   state_d = ST_CSUM;
        ST_CSUM:  state_d = ST_IDLE;
`else
        ST_ALO:   state_d = ST_IDLE;
`endif
        default:  state_d = ST_IDLE;
      endcase
    end
    tx_data_d = frame_byte(state_d, hold_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      hold_q          <= '0;
      tx_valid_q      <= 1'b0;
      tx_data_q       <= 8'h00;
      cnt_frames_q    <= '0;
      cnt_tx_stalls_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      tx_valid_q <= (state_d != ST_IDLE);
      tx_data_q  <= tx_data_d;
      if (tx_hs && in_last)
        cnt_frames_q <= cnt_frames_q + 32'd1;
      if (tx_valid_q && !tx_ready)
        cnt_tx_stalls_q <= cnt_tx_stalls_q + 32'd1;
    end
  end

  assign tx_valid      = tx_valid_q;
  assign busy          = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign cnt_frames    = cnt_frames_q;
  assign cnt_tx_stalls = cnt_tx_stalls_q;

endmodule

// File: tb/tb_atomik_event_packer.sv
// Bench for atomik_event_packer: queue-based frame model checked every cycle plus directed literal frames.
module tb_atomik_event_packer;
  import atomik_pkg::*;

`ifdef ATOMIK_PACKER_CHECKSUM_EN
  localparam int FL = FRAME_LEN_CSUM;
`else
  localparam int FL = FRAME_LEN_BASE;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_delta = 1'b0, ev_first_touch = 1'b0, ev_drop_invalid = 1'b0, ev_is_zero = 1'b0;
  logic [9:0]  ev_addr = '0;
  logic [3:0]  ev_delta_val = '0;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        busy;
  logic [31:0] cnt_frames, cnt_tx_stalls;

  always #5 clk = ~clk;

  atomik_event_packer #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_delta(ev_delta), .ev_first_touch(ev_first_touch),
    .ev_drop_invalid(ev_drop_invalid), .ev_is_zero(ev_is_zero),
    .ev_addr(ev_addr), .ev_delta_val(ev_delta_val),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .busy(busy), .cnt_frames(cnt_frames), .cnt_tx_stalls(cnt_tx_stalls)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of the bytes still owed to the UART, built from each accepted event.
  logic [7:0]  mq[$];
  bit          ml[$];
  logic [7:0]  sent[$];
  int unsigned m_frames = 0, m_stalls = 0;
  bit          armed = 0;

  function automatic void push_frame(input logic d, ft, dr, z, input logic [3:0] dv, input logic [9:0] a);
    logic [7:0] f, hi, lo;
    f  = {d, ft, dr, z, dv};
    hi = {6'b0, a[9:8]};
    lo = a[7:0];
    mq.push_back(8'hA5);      ml.push_back(0);
    mq.push_back(f);          ml.push_back(0);
    mq.push_back(hi);         ml.push_back(0);
    mq.push_back(lo);         ml.push_back(FL == 4);
    if (FL == 5) begin
      mq.push_back(f ^ hi ^ lo); ml.push_back(1);
    end
  endfunction

  always @(negedge clk) begin
    bit exp_v, exp_rdy;
    exp_v   = (mq.size() != 0);
    exp_rdy = !exp_v || (mq.size() == 1 && tx_ready);
    if (armed) begin
      check("tx_valid", {31'b0, tx_valid}, {31'b0, exp_v});
      check("busy", {31'b0, busy}, {31'b0, exp_v});
      check("ev_ready", {31'b0, ev_ready}, {31'b0, exp_rdy});
      if (exp_v) check("tx_data", {24'b0, tx_data}, {24'b0, mq[0]});
      check("cnt_frames", cnt_frames, m_frames);
      check("cnt_tx_stalls", cnt_tx_stalls, m_stalls);
    end
    if (!rst_n) begin
      mq.delete(); ml.delete();
      m_frames = 0; m_stalls = 0;
      armed = 1;
    end else if (armed) begin
      if (exp_v && tx_ready) begin
        sent.push_back(tx_data);
        if (ml[0]) m_frames++;
        void'(mq.pop_front());
        void'(ml.pop_front());
      end
      if (exp_v && !tx_ready) m_stalls++;
      if (ev_valid && exp_rdy)
        push_frame(ev_delta, ev_first_touch, ev_drop_invalid, ev_is_zero, ev_delta_val, ev_addr);
    end
  end

  task automatic send_event(input logic d, ft, dr, z, input logic [3:0] dv, input logic [9:0] a);
    bit got;
    got = 0;
    ev_delta = d; ev_first_touch = ft; ev_drop_invalid = dr; ev_is_zero = z;
    ev_delta_val = dv; ev_addr = a; ev_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ev_ready) begin got = 1; break; end
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ev_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_sent(input string name, input logic [7:0] e0, e1, e2, e3, e4);
    logic [7:0] exp [5];
    exp = '{e0, e1, e2, e3, e4};
    check({name, "_len"}, sent.size(), FL);
    for (int i = 0; i < FL && i < sent.size(); i++)
      check(name, {24'b0, sent[i]}, {24'b0, exp[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h00);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_frames", cnt_frames, 32'd0);
    check("rst_stalls", cnt_tx_stalls, 32'd0);
    check("rst_ev_ready", {31'b0, ev_ready}, 32'd1);

    // Single frame, addr 0x2A7 delta=1 delta_val=9.
    sent.delete();
    send_event(1, 0, 0, 0, 4'h9, 10'h2A7);
    wait_idle();
    check_sent("single", 8'hA5, 8'h89, 8'h02, 8'hA7, 8'h2C);
    check("single_frames", cnt_frames, 32'd1);

    // Backpressure on FLAGS for three cycles.
    sent.delete();
    send_event(1, 0, 0, 0, 4'h9, 10'h2A7);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    check("stall_hold", {24'b0, tx_data}, 32'h89);
    repeat (2) @(posedge clk);
    #1 tx_ready = 1'b1;
    check("stall_hold2", {24'b0, tx_data}, 32'h89);
    wait_idle();
    check("stall_count", cnt_tx_stalls, 32'd3);
    check("stall_frames", cnt_frames, 32'd2);
    check_sent("stall", 8'hA5, 8'h89, 8'h02, 8'hA7, 8'h2C);

    // Back-to-back frames with the next event already waiting.
    sent.delete();
    send_event(1, 0, 0, 0, 4'h9, 10'h2A7);
    ev_first_touch = 1'b1; ev_addr = 10'h155; ev_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!tx_valid) break;
      n++;
      if (ev_valid && ev_ready) begin
        @(posedge clk); #1;
        ev_valid = 1'b0;
      end
    end
    check("b2b_contig", n, 2 * FL);
    check("b2b_bytes", sent.size(), 2 * FL);
    if (sent.size() > FL) check("b2b_sync2", {24'b0, sent[FL]}, 32'hA5);
    check("b2b_frames", cnt_frames, 32'd4);
    @(posedge clk); #1;

    // Flag mapping: drop_invalid + is_zero, addr 0.
    sent.delete();
    send_event(0, 0, 1, 1, 4'h0, 10'h000);
    wait_idle();
    check_sent("flags", 8'hA5, 8'h30, 8'h00, 8'h00, 8'h30);

    // Reset during AHI aborts the frame.
    send_event(0, 1, 0, 0, 4'h3, 10'h155);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ahi_byte", {24'b0, tx_data}, 32'h01);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_frames", cnt_frames, 32'd0);
    check("mid_rst_stalls", cnt_tx_stalls, 32'd0);
    check("mid_rst_ready", {31'b0, ev_ready}, 32'd1);
    sent.delete();
    send_event(0, 1, 0, 0, 4'h3, 10'h155);
    wait_idle();
    check_sent("post_rst", 8'hA5, 8'h43, 8'h01, 8'h55, 8'h17);
    check("post_rst_frames", cnt_frames, 32'd1);

    // ev_valid held high over three frame times: exactly three captures.
    ev_valid = 1'b1;
    r = 0;
    for (int i = 0; i < 3 * FL; i++) begin
      @(negedge clk);
      if (ev_ready) r++;
    end
    @(posedge clk); #1;
    ev_valid = 1'b0;
    check("hold_ready_cycles", r, 32'd3);
    wait_idle();
    check("hold_frames", cnt_frames, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
